assoc_wb_cache: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache for the MIPS core's load/store path.

---
 rtl/assoc_wb_cache_pkg.sv | 19 +
 rtl/assoc_wb_cache_way.sv | 66 ++++++
 rtl/assoc_wb_cache.sv | 204 ++++++++++++++++++++
 tb/tb_assoc_wb_cache.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_wb_cache_pkg.sv
// Shared types and constants for the set-associative write-back data cache.
// Holds the FSM state encoding, word width and a width helper for way indices.
package assoc_wb_cache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2,
        ST_RESPOND   = 2'd3
    } cache_state_t;

    // A direct-mapped cache still needs a 1-bit way index so vectors stay legal.
    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/assoc_wb_cache_way.sv
// One way of the cache: per-set valid/dirty/tag/data with a combinational read
// port and a single write port that either installs a full line or merges one word.
module assoc_wb_cache_way
    import assoc_wb_cache_pkg::*;
#(
    parameter int  SETS            = 32,
    parameter int  WORDS_PER_BLOCK = 4,
    parameter int  TAG_W           = 23,
    localparam int IDX_W           = $clog2(SETS),
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK),
    localparam int LINE_W          = WORD_W * WORDS_PER_BLOCK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic              install,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic              wr_dirty,
    input  logic              merge,
    input  logic [OFF_W-1:0]  merge_off,
    input  logic [WORD_W-1:0] merge_data,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line
);

    typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] line_t;

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    line_t            data_q [SETS];

    // NOTE: non-blocking assignments for all sequential state so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (install) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= wr_dirty;
        end else if (merge) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything, so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= line_t'(wr_line);
        end else if (merge) begin
            data_q[idx][merge_off] <= merge_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

endmodule

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate data cache with round-robin
// replacement. Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module assoc_wb_cache
    import assoc_wb_cache_pkg::*;
#(
    parameter int  ADDR_W          = 32,
    parameter int  WAYS            = 2,
    parameter int  SETS            = 32,
    parameter int  WORDS_PER_BLOCK = 4,
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK),
    localparam int IDX_W           = $clog2(SETS),
    localparam int TAG_W           = ADDR_W - IDX_W - OFF_W - 2,
    localparam int LINE_W          = WORD_W * WORDS_PER_BLOCK,
    localparam int MA_W            = ADDR_W - 2 - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              complete,
    output logic              mem_re,
    output logic              mem_we,
    output logic [MA_W-1:0]   mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_complete
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int WAY_W = way_idx_w(WAYS);

    typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] line_t;

    cache_state_t state_q;
    logic [WAY_W-1:0] victim_q;
    logic [WAY_W-1:0] rr_q [SETS];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req;

    logic [WAYS-1:0]  way_valid;
    logic [WAYS-1:0]  way_dirty;
    logic [TAG_W-1:0] way_tag  [WAYS];
    line_t            way_line [WAYS];

    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    line_t            hit_line;
    logic [WAY_W-1:0] victim_way;
    logic             victim_found;
    logic             victim_dirty;
    line_t            fill_line;
    logic             install_en;
    logic             merge_en;

    assign req_off = addr[OFF_W+1:2];
    assign req_idx = addr[OFF_W+2 +: IDX_W];
    assign req_tag = addr[ADDR_W-1 -: TAG_W];
    assign req     = re | we;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assoc_wb_cache_way #(
            .SETS            (SETS),
            .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
            .TAG_W           (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .idx        (req_idx),
            .install    (install_en && (victim_q == WAY_W'(w))),
            .wr_tag     (req_tag),
            .wr_line    (fill_line),
            .wr_dirty   (we),
            .merge      (merge_en && hit_vec[w]),
            .merge_off  (req_off),
            .merge_data (din),
            .rd_valid   (way_valid[w]),
            .rd_dirty   (way_dirty[w]),
            .rd_tag     (way_tag[w]),
            .rd_line    (way_line[w])
        );

        assign hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    assign hit = |hit_vec;

    // NOTE: every variable written in an always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit_line = way_line[hit_way];

    // Lowest invalid way wins; only a full set falls back to round-robin.
    always_comb begin
        victim_way   = rr_q[req_idx];
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !way_valid[w]) begin
                victim_way   = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    assign victim_dirty = way_dirty[victim_way];

    // A store miss allocates the fetched line with the store already folded in.
    always_comb begin
        fill_line = line_t'(mem_rdata);
        if (we) fill_line[req_off] = din;
    end

    assign install_en = !rst && (state_q == ST_FILL) && mem_complete;
    assign merge_en   = !rst && (state_q == ST_IDLE) && we && hit;

    always_comb begin
        complete = 1'b0;
        dout     = '0;
        case (state_q)
            ST_IDLE:    complete = !req || hit;
            ST_RESPOND: complete = 1'b1;
            default:    complete = 1'b0;
        endcase
        // In RESPOND the installed line hits, so the same read path serves both cases.
        if ((state_q == ST_IDLE || state_q == ST_RESPOND) && hit) dout = hit_line[req_off];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            victim_q  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req && !hit) begin
                        victim_q <= victim_way;
                        if (victim_dirty) begin
                            state_q   <= ST_WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {way_tag[victim_way], req_idx};
                            mem_wdata <= way_line[victim_way];
                        end else begin
                            state_q  <= ST_FILL;
                            mem_re   <= 1'b1;
                            mem_addr <= {req_tag, req_idx};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_complete) begin
                        state_q  <= ST_FILL;
                        mem_we   <= 1'b0;
                        mem_re   <= 1'b1;
                        mem_addr <= {req_tag, req_idx};
                    end
                end
                ST_FILL: begin
                    if (mem_complete) begin
                        state_q <= ST_RESPOND;
                        mem_re  <= 1'b0;
                        if (WAYS > 1) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == ST_IDLE && req) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Self-checking bench for assoc_wb_cache: vector table plus scoreboard of load data,
// a latency-3 backing RAM model, and a hand-written reset-during-fill sequence.
module tb_assoc_wb_cache;

    localparam int LAT = 3;

    logic         clk;
    logic         rst;
    logic [31:0]  addr;
    logic         re;
    logic         we;
    logic [31:0]  din;
    logic [31:0]  dout;
    logic         complete;
    logic         mem_re;
    logic         mem_we;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_complete;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    assoc_wb_cache dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .re           (re),
        .we           (we),
        .din          (din),
        .dout         (dout),
        .complete     (complete),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_complete (mem_complete)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic        we;
        logic [31:0] din;
        logic        exp_hit;
        int          exp_cycles;
        logic        exp_wb;
        logic [27:0] exp_wb_addr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] bmem    [logic [27:0]];
    logic [31:0]  ref_mem [logic [29:0]];
    logic [31:0]  exp_q   [$];
    logic [27:0]  wb_addr_q [$];
    logic [127:0] wb_data_q [$];

    int fills, wbs, first_evt;
    bit overlap;
    bit prev_re, prev_we;

    function automatic logic [31:0] default_word(input logic [27:0] blk, input logic [1:0] w);
        return {4'hA, blk[23:0], 2'b00, w};
    endfunction

    function automatic logic [127:0] default_line(input logic [27:0] blk);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = default_word(blk, 2'(w));
        return l;
    endfunction

    // Core-visible memory: the last value stored to a word, else the RAM's initial pattern.
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return default_word(a[31:4], a[3:2]);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing RAM: each mem_re/mem_we is acknowledged after LAT cycles with a one-cycle mem_complete.
    initial begin
        int cnt;
        cnt          = 0;
        mem_complete = 1'b0;
        mem_rdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt          = 0;
                mem_complete = 1'b0;
            end else begin
                if (mem_complete) begin
                    mem_complete = 1'b0;
                    cnt          = 0;
                end
                if (mem_re || mem_we) begin
                    cnt++;
                    if (cnt == LAT) begin
                        mem_complete = 1'b1;
                        if (mem_we) begin
                            bmem[mem_addr] = mem_wdata;
                            wb_addr_q.push_back(mem_addr);
                            wb_data_q.push_back(mem_wdata);
                        end else begin
                            mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : default_line(mem_addr);
                        end
                    end
                end
            end
        end
    end

    // Bus monitor: counts bursts and records which request type came first.
    initial begin
        prev_re = 1'b0;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_re && mem_we) overlap = 1'b1;
            if (mem_re && !prev_re) begin
                fills++;
                if (first_evt == 0) first_evt = 1;
            end
            if (mem_we && !prev_we) begin
                wbs++;
                if (first_evt == 0) first_evt = 2;
            end
            prev_re = mem_re;
            prev_we = mem_we;
        end
    end

    task automatic do_req(input vec_t v, input string name);
        int cyc;
        bit done;
        logic [127:0] exp_line;
        logic [27:0]  wa;
        fills     = 0;
        wbs       = 0;
        overlap   = 1'b0;
        first_evt = 0;
        addr = v.addr;
        re   = v.re;
        we   = v.we;
        din  = v.din;
        if (v.re && !v.we) exp_q.push_back(ref_read(v.addr));
        if (v.we) ref_mem[v.addr[31:2]] = v.din;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc <= 50) begin
            @(negedge clk);
            if (complete) begin
                done = 1'b1;
                check({name, "_latency"}, 128'(cyc), 128'(v.exp_cycles));
                if (v.re && !v.we) check({name, "_dout"}, 128'(dout), 128'(exp_q.pop_front()));
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check({name, "_completed"}, 128'(done), 128'(1));
        if (!done && v.re && !v.we) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        re = 1'b0;
        we = 1'b0;
        check({name, "_fills"}, 128'(fills), v.exp_hit ? 128'(0) : 128'(1));
        check({name, "_writebacks"}, 128'(wbs), 128'(v.exp_wb));
        check({name, "_no_overlap"}, 128'(overlap), 128'(0));
        if (v.exp_wb) begin
            check({name, "_we_first"}, 128'(first_evt), 128'(2));
            if (wb_addr_q.size() > 0) begin
                wa = wb_addr_q.pop_front();
                check({name, "_wb_addr"}, 128'(wa), 128'(v.exp_wb_addr));
                for (int w = 0; w < 4; w++) exp_line[w*32 +: 32] = ref_read({v.exp_wb_addr, 2'(w), 2'b00});
                check({name, "_wb_line"}, wb_data_q.pop_front(), exp_line);
            end
        end
    endtask

    vec_t vecs[15];

    initial begin
        //          addr          re    we    din           hit   cyc wb    wb_addr
        vecs[0]  = '{32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 4, 1'b0, 28'h0};
        vecs[1]  = '{32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        vecs[2]  = '{32'h108, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 0, 1'b0, 28'h0};
        vecs[3]  = '{32'h500, 1'b1, 1'b0, 32'h0,        1'b0, 4, 1'b0, 28'h0};
        vecs[4]  = '{32'h900, 1'b1, 1'b0, 32'h0,        1'b0, 7, 1'b1, 28'h10};
        vecs[5]  = '{32'h108, 1'b1, 1'b0, 32'h0,        1'b0, 4, 1'b0, 28'h0};
        vecs[6]  = '{32'h204, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 4, 1'b0, 28'h0};
        vecs[7]  = '{32'h204, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        vecs[8]  = '{32'h200, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        vecs[9]  = '{32'h10C, 1'b1, 1'b1, 32'h12345678, 1'b1, 0, 1'b0, 28'h0};
        vecs[10] = '{32'h10C, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        // After a reset mid-fill: everything is cold again, dirty lines are gone.
        vecs[11] = '{32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 4, 1'b0, 28'h0};
        vecs[12] = '{32'h108, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        vecs[13] = '{32'h10C, 1'b1, 1'b0, 32'h0,        1'b1, 0, 1'b0, 28'h0};
        vecs[14] = '{32'h204, 1'b1, 1'b0, 32'h0,        1'b0, 4, 1'b0, 28'h0};

        rst  = 1'b1;
        addr = '0;
        re   = 1'b0;
        we   = 1'b0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_complete_idle", 128'(complete), 128'(1));
        check("reset_dout", 128'(dout), 128'(0));
        check("reset_mem_re", 128'(mem_re), 128'(0));
        check("reset_mem_we", 128'(mem_we), 128'(0));
        check("reset_mem_addr", 128'(mem_addr), 128'(0));
        check("reset_mem_wdata", mem_wdata, 128'(0));
`ifdef CACHE_STATS_EN
        check("reset_hit_count", 128'(hit_count), 128'(0));
        check("reset_miss_count", 128'(miss_count), 128'(0));
`endif

        for (int i = 0; i <= 10; i++) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
`ifdef CACHE_STATS_EN
            if (i == 1) begin
                check("stats_hit_count", 128'(hit_count), 128'(1));
                check("stats_miss_count", 128'(miss_count), 128'(1));
            end
`endif
        end

        // Reset while a fill is in flight: the bus request must drop on the next edge.
        addr = 32'h600;
        re   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("midfill_mem_re_active", 128'(mem_re), 128'(1));
        rst = 1'b1;
        re  = 1'b0;
        @(posedge clk);
        #1;
        check("midfill_reset_mem_re", 128'(mem_re), 128'(0));
        check("midfill_reset_mem_we", 128'(mem_we), 128'(0));
        rst = 1'b0;
        check("midfill_reset_idle_complete", 128'(complete), 128'(1));
`ifdef CACHE_STATS_EN
        check("midfill_reset_counters", 128'({hit_count, miss_count}), 128'(0));
`endif
        // Stores still sitting dirty in the cache are lost.
        ref_mem.delete(30'(32'h204 >> 2));
        ref_mem.delete(30'(32'h10C >> 2));

        for (int i = 11; i < 15; i++) do_req(vecs[i], $sformatf("vec%0d", i));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
